// File: rtl/collision_scorer.sv
// Per-tick player/obstacle overlap check with BCD hit score, lives and a game-state FSM.
// Define COLLISION_SCORER_LIVES_EN to enable lives/OVER; otherwise every hit is PLAY -> HIT -> PLAY.
module collision_scorer #(
    parameter int HIT_RADIUS   = 10,
    parameter int LIVES_INIT   = 3,
    parameter int INVULN_TICKS = 8,
    parameter int NUM_OBS      = 4
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic                    tick,
    input  logic                    start_btn,
    input  logic [9:0]              px,
    input  logic [9:0]              py,
    input  logic [10*NUM_OBS-1:0]   ox,
    input  logic [10*NUM_OBS-1:0]   oy,
    input  logic [NUM_OBS-1:0]      ovalid,
    output logic [15:0]             hit_bcd,
    output logic [2:0]              lives,
    output logic                    flash,
    output logic                    game_over,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [9:0] RADIUS   = 10'(HIT_RADIUS);
    localparam logic [7:0] INV_LOAD = 8'(INVULN_TICKS);
`ifdef COLLISION_SCORER_LIVES_EN
    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
`else
    localparam logic [2:0] LIVES_UNUSED = 3'(LIVES_INIT);
`endif

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          flash_q, flash_d;
    logic          game_over_q, game_over_d;
`ifdef COLLISION_SCORER_LIVES_EN
    logic [2:0]    lives_q, lives_d;
`endif

    logic                start_p;
    logic                any_hit;
    logic [NUM_OBS-1:0]  slot_hit;

    // Larger-minus-smaller keeps the distance unsigned, so px=0 vs ox=5 is 5, not a wrap.
    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        logic [9:0] ox_i, oy_i, dx, dy;
        assign ox_i        = ox[10*i +: 10];
        assign oy_i        = oy[10*i +: 10];
        assign dx          = (px >= ox_i) ? (px - ox_i) : (ox_i - px);
        assign dy          = (py >= oy_i) ? (py - oy_i) : (oy_i - py);
        assign slot_hit[i] = ovalid[i] && (dx <= RADIUS) && (dy <= RADIUS);
    end

    assign any_hit = |slot_hit;
    assign start_p = sync_q[1] & ~sync_q[2];

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        sync_d  = {sync_q[1:0], start_btn};
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef COLLISION_SCORER_LIVES_EN
        lives_d = lives_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                // Start outranks a coincident tick: no evaluation on that cycle.
                if (start_p) begin
                    state_d = ST_PLAY;
                    bcd_d   = 16'h0000;
`ifdef COLLISION_SCORER_LIVES_EN
                    lives_d = LIVES_LOAD;
`endif
                end
            end
            ST_PLAY: begin
                if (tick && any_hit) begin
                    bcd_d   = bcd_inc(bcd_q);
                    state_d = ST_HIT;
                    cnt_d   = INV_LOAD;
`ifdef COLLISION_SCORER_LIVES_EN
                    if (lives_q <= 3'd1) begin
                        state_d = ST_OVER;
                        cnt_d   = 8'd0;
                        lives_d = 3'd0;
                    end else begin
                        lives_d = lives_q - 3'd1;
                    end
`endif
                end
            end
            ST_HIT: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_PLAY;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flash_d = (state_d == ST_HIT);
`ifdef COLLISION_SCORER_LIVES_EN
        game_over_d = (state_d == ST_OVER);
`else
        game_over_d = 1'b0;
`endif
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sync_q      <= 3'b000;
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            bcd_q       <= 16'h0000;
            flash_q     <= 1'b0;
            game_over_q <= 1'b0;
`ifdef COLLISION_SCORER_LIVES_EN
            lives_q     <= LIVES_LOAD;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            flash_q     <= flash_d;
            game_over_q <= game_over_d;
`ifdef COLLISION_SCORER_LIVES_EN
            lives_q     <= lives_d;
`endif
        end
    end

    assign hit_bcd   = bcd_q;
    assign flash     = flash_q;
    assign game_over = game_over_q;
    assign state_o   = state_q;
`ifdef COLLISION_SCORER_LIVES_EN
    assign lives     = lives_q;
`else
    assign lives     = 3'd0;
`endif

endmodule

// File: tb/tb_collision_scorer.sv
// Scoreboard bench for collision_scorer: a behavioural game model queues expected outputs per stimulus step.
module tb_collision_scorer;
    localparam int HR  = 10;
    localparam int LI  = 3;
    localparam int INV = 4;

    logic        ClkPort = 1'b0;
    logic        Reset, tick, start_btn;
    logic [9:0]  px, py;
    logic [39:0] ox, oy;
    logic [3:0]  ovalid;
    logic [15:0] hit_bcd;
    logic [2:0]  lives;
    logic        flash, game_over;
    logic [1:0]  state_o;

    always #5 ClkPort = ~ClkPort;

    collision_scorer #(.HIT_RADIUS(HR), .LIVES_INIT(LI), .INVULN_TICKS(INV), .NUM_OBS(4)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .tick(tick), .start_btn(start_btn),
        .px(px), .py(py), .ox(ox), .oy(oy), .ovalid(ovalid),
        .hit_bcd(hit_bcd), .lives(lives), .flash(flash), .game_over(game_over), .state_o(state_o)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] bcd;
        logic [2:0]  lv;
        logic        fl;
        logic        go;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;
    int   errors = 0;
    int   checks = 0;

    int m_state, m_cnt, m_hits, m_lives;
    int b_px, b_py;
    int b_ox[4], b_oy[4];
    bit b_ov[4];

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic exp_t model_exp();
        exp_t x;
        x.st  = 2'(m_state);
        x.bcd = to_bcd(m_hits);
`ifdef COLLISION_SCORER_LIVES_EN
        x.lv  = 3'(m_lives);
`else
        x.lv  = 3'd0;
`endif
        x.fl  = (m_state == 2);
        x.go  = (m_state == 3);
        return x;
    endfunction

    function automatic exp_t observed();
        return {state_o, hit_bcd, lives, flash, game_over};
    endfunction

    function automatic bit bench_overlap();
        bit hit = 0;
        for (int i = 0; i < 4; i++) begin
            int dx = b_px - b_ox[i];
            int dy = b_py - b_oy[i];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (b_ov[i] && dx <= HR && dy <= HR) hit = 1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_hits = 0; m_lives = LI;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 3) begin
            m_state = 1; m_hits = 0; m_lives = LI;
        end
    endtask

    task automatic model_tick(input bit ovl);
        if (m_state == 1 && ovl) begin
            if (m_hits < 9999) m_hits++;
`ifdef COLLISION_SCORER_LIVES_EN
            if (m_lives == 1) begin
                m_lives = 0; m_state = 3;
            end else begin
                m_lives--; m_state = 2; m_cnt = INV;
            end
`else
            m_state = 2; m_cnt = INV;
`endif
        end else if (m_state == 2) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 1;
        end
    endtask

    task automatic place(input int slot, input int x, input int y, input bit v);
        b_ox[slot] = x; b_oy[slot] = y; b_ov[slot] = v;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) place(i, 500, 500, 1'b0);
    endtask

    task automatic drive_pos();
        px = 10'(b_px); py = 10'(b_py);
        for (int i = 0; i < 4; i++) begin
            ox[10*i +: 10] = 10'(b_ox[i]);
            oy[10*i +: 10] = 10'(b_oy[i]);
            ovalid[i]      = b_ov[i];
        end
    endtask

    task automatic do_tick();
        @(negedge ClkPort);
        drive_pos();
        tick = 1'b1;
        model_tick(bench_overlap());
        sb.push_back(model_exp());
        @(posedge ClkPort);
        #1 tick = 1'b0;
    endtask

    task automatic press_start();
        @(negedge ClkPort);
        start_btn = 1'b1;
        repeat (4) @(negedge ClkPort);
        start_btn = 1'b0;
        repeat (4) @(negedge ClkPort);
        model_start();
    endtask

    task automatic restart();
        @(negedge ClkPort);
        Reset = 1'b1;
        model_reset();
        @(negedge ClkPort);
        Reset = 1'b0;
        press_start();
    endtask

    task automatic test_reset();
        Reset = 1'b1; tick = 1'b0; start_btn = 1'b0;
        b_px = 100; b_py = 100;
        clear_slots();
        drive_pos();
        #23;
        model_reset();
        sb.push_back(model_exp());
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset: got %h want %h", o, e); end
        @(negedge ClkPort);
        Reset = 1'b0;
    endtask

    task automatic test_first_hit();
        restart();
        sb.push_back(model_exp());
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL start_to_play: got %h want %h", o, e); end
        b_px = 100; b_py = 100;
        place(0, 110, 95, 1'b1);
        do_tick();
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL first_hit: got %h want %h", o, e); end
        checks++;
        if (hit_bcd !== 16'h0001 || flash !== 1'b1) begin
            errors++; $display("FAIL first_hit_const: bcd=%h flash=%b want 0001/1", hit_bcd, flash);
        end
        clear_slots();
        for (int i = 0; i < INV; i++) begin
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL recover[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_no_hit();
        b_px = 100; b_py = 100;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) place(0, 111, 100, 1'b1);
            else       place(0, 100, 100, 1'b0);
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL no_hit[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (state_o !== 2'b01 || hit_bcd !== 16'h0001) begin
            errors++; $display("FAIL no_hit_const: st=%0d bcd=%h want 1/0001", state_o, hit_bcd);
        end
    endtask

    task automatic test_continuous();
        restart();
        b_px = 200; b_py = 200;
        clear_slots();
        place(0, 205, 195, 1'b1);
        for (int i = 0; i < 3 * (INV + 1); i++) begin
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL continuous[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (hit_bcd !== 16'h0003) begin
            errors++; $display("FAIL continuous_count: bcd=%h want 0003", hit_bcd);
        end
    endtask

    task automatic test_multi_slot();
        restart();
        b_px = 300; b_py = 300;
        clear_slots();
        place(0, 302, 298, 1'b1);
        place(2, 296, 309, 1'b1);
        do_tick();
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL multi_slot: got %h want %h", o, e); end
        checks++;
        if (hit_bcd !== 16'h0001) begin
            errors++; $display("FAIL multi_slot_count: bcd=%h want 0001", hit_bcd);
        end
    endtask

    task automatic test_boundary();
        restart();
        b_px = 100; b_py = 100;
        clear_slots();
        place(1, 110, 90, 1'b1);
        for (int i = 0; i < INV + 2; i++) begin
            if (i == 1) clear_slots();
            if (i == INV + 1) begin
                b_px = 0; b_py = 0;
                place(1, 5, 5, 1'b1);
            end
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL boundary[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (hit_bcd !== 16'h0002 || state_o !== 2'b10) begin
            errors++; $display("FAIL boundary_const: bcd=%h st=%0d want 0002/2", hit_bcd, state_o);
        end
    endtask

`ifdef COLLISION_SCORER_LIVES_EN
    task automatic test_lives();
        restart();
        b_px = 100; b_py = 100;
        for (int h = 0; h < 3; h++) begin
            for (int i = 0; i < INV + 1; i++) begin
                if (i == 0) place(0, 100, 100, 1'b1);
                else        clear_slots();
                if (h < 2 || i == 0) begin
                    do_tick();
                    e = sb.pop_front(); o = observed(); checks++;
                    if (o !== e) begin errors++; $display("FAIL lives[%0d.%0d]: got %h want %h", h, i, o, e); end
                end
            end
        end
        place(0, 100, 100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL over_hold[%0d]: got %h want %h", i, o, e); end
        end
        checks++;
        if (game_over !== 1'b1 || lives !== 3'd0 || hit_bcd !== 16'h0003) begin
            errors++; $display("FAIL over_const: go=%b lv=%0d bcd=%h want 1/0/0003", game_over, lives, hit_bcd);
        end
        press_start();
        sb.push_back(model_exp());
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL over_restart: got %h want %h", o, e); end
        checks++;
        if (state_o !== 2'b01 || lives !== 3'd3 || hit_bcd !== 16'h0000) begin
            errors++; $display("FAIL restart_const: st=%0d lv=%0d bcd=%h want 1/3/0000", state_o, lives, hit_bcd);
        end
    endtask
`else
    task automatic test_bcd_sat();
        int guard = 0;
        restart();
        b_px = 50; b_py = 50;
        clear_slots();
        place(3, 55, 45, 1'b1);
        while ((m_hits < 9999 || guard < 2 * (INV + 1)) && guard < 60000) begin
            if (m_hits == 9999) guard++;
            do_tick();
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin errors++; $display("FAIL bcd_run hits=%0d: got %h want %h", m_hits, o, e); end
            if (m_state == 2 && m_cnt == INV) begin
                if (m_hits == 10 && hit_bcd !== 16'h0010) begin
                    errors++; $display("FAIL bcd_carry10: got %h want 0010", hit_bcd);
                end
                if (m_hits == 100 && hit_bcd !== 16'h0100) begin
                    errors++; $display("FAIL bcd_carry100: got %h want 0100", hit_bcd);
                end
            end
        end
        checks++;
        if (hit_bcd !== 16'h9999 || game_over !== 1'b0) begin
            errors++; $display("FAIL bcd_saturate: bcd=%h go=%b want 9999/0", hit_bcd, game_over);
        end
    endtask
`endif

    task automatic test_reset_mid_hit();
        restart();
        b_px = 100; b_py = 100;
        clear_slots();
        place(0, 100, 100, 1'b1);
        do_tick();
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL enter_hit: got %h want %h", o, e); end
        @(negedge ClkPort);
        #1 Reset = 1'b1;
        #1;
        model_reset();
        sb.push_back(model_exp());
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin errors++; $display("FAIL async_reset: got %h want %h", o, e); end
        checks++;
        if (flash !== 1'b0 || state_o !== 2'b00) begin
            errors++; $display("FAIL async_reset_const: flash=%b st=%0d want 0/0", flash, state_o);
        end
        @(negedge ClkPort);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_hit();
        test_no_hit();
        test_continuous();
        test_multi_slot();
        test_boundary();
`ifdef COLLISION_SCORER_LIVES_EN
        test_lives();
`else
        test_bcd_sat();
`endif
        test_reset_mid_hit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_scorer.md
Name: collision_scorer

Overview:
Sits between the block controllers and the seven-segment scan logic. Once per movement tick it compares the player block position against up to four obstacle positions. It scores hits as a 4-digit BCD count and manages lives with an invulnerability window. It runs a small game-state FSM (IDLE/PLAY/HIT/OVER) whose outputs drive the colour override and the SSD digits.

Parameters:
HIT_RADIUS, 10, max per-axis absolute distance (pixels) counted as overlap
LIVES_INIT, 3, lives loaded on reset and on start (1..7)
INVULN_TICKS, 8, ticks spent in HIT before collisions are evaluated again (1..255)
NUM_OBS, 4, number of obstacle slots (fixed packing width below assumes 4)

Ports:
ClkPort  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-high reset
tick  in  1  one-ClkPort-cycle strobe, rising edge of move clock, gates all evaluation
start_btn  in  1  raw start button level, asynchronous to ClkPort
px  in  10  player x
py  in  10  player y
ox  in  40  obstacle x, slot i at [10i+9:10i]
oy  in  40  obstacle y, same packing
ovalid  in  4  per-slot enable; invalid slots never collide
hit_bcd  out  16  hit count, 4 BCD digits, [3:0] = units
lives  out  3  remaining lives
flash  out  1  high while state = HIT (colour override request)
game_over  out  1  high while state = OVER
state_o  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER

Behaviour:
- Reset (async, ClkPort domain): state IDLE, hit_bcd 0x0000, lives LIVES_INIT, flash 0, game_over 0, invuln counter 0, sync flops 0.
- start_btn: 2-flop synchroniser, then rising-edge detect giving start_p, a 1-cycle pulse.
- Overlap per slot: ovalid[i] && |px-ox_i| <= HIT_RADIUS && |py-oy_i| <= HIT_RADIUS.
  - Absolute difference computed as larger minus smaller in 10 bits; no wrap. Example: px=0, ox=5 gives diff 5.
  - any_hit = OR over slots. Several slots overlapping on one tick count as one hit.
- FSM, all transitions registered; outputs reflect new state one ClkPort cycle after the triggering edge.
  - IDLE: start_p -> PLAY. On entry to PLAY: hit_bcd cleared, lives reloaded to LIVES_INIT.
  - PLAY: tick && any_hit -> hit processing:
    - hit_bcd incremented in BCD. Digit carries at 9. Saturates at 0x9999, no wrap.
    - lives decremented.
    - If lives was 1: go to OVER (lives 0). Otherwise go to HIT with invuln counter = INVULN_TICKS.
  - HIT: every tick decrements the invuln counter. When the counter reaches 0 on a tick, go to PLAY. Collisions are ignored in HIT. The first evaluation happens on the next tick in PLAY.
  - OVER: holds; hit_bcd and lives frozen. start_p -> PLAY with clear/reload as above.
  - start_p in PLAY or HIT: ignored.
- tick without overlap in PLAY: no change. tick and start_p in the same cycle in IDLE/OVER: start wins; that tick does no evaluation.
- flash = (state==HIT), game_over = (state==OVER); both registered.
- Reset asserted mid-HIT or mid-OVER returns to the reset values immediately, regardless of tick.

Optional Feature:
COLLISION_SCORER_LIVES_EN
- Defined: lives/OVER behaviour as above.
- Undefined:
  - lives output tied to 0; no decrement.
  - Every hit goes PLAY -> HIT -> PLAY; OVER is unreachable and game_over is constant 0.
  - hit_bcd still counts and saturates.

Test Plan:
- Reset, pulse start_btn (held 4 cycles), player (100,100), slot0 (110,95) valid, one tick -> state HIT, hit_bcd 0x0001, lives 2, flash 1 one cycle after the tick.
- Slot0 at (111,100), or slot0 overlapping with ovalid[0]=0, apply ticks -> no hit, state stays PLAY, hit_bcd 0x0000.
- Overlap held continuously with INVULN_TICKS=8 -> exactly one hit per 9 ticks (8 HIT ticks plus 1 PLAY evaluation). Slots 0 and 2 overlapping together -> still +1.
- Preload via repeated hits with LIVES_INIT=7 and macro undefined -> 0x0009 goes to 0x0010, 0x0099 to 0x0100, 0x9999 holds at 0x9999.
- LIVES_INIT=3, three separated hits -> lives 3,2,1,0. Third hit goes directly to OVER with game_over 1. Further ticks change nothing. start -> PLAY, 0x0000, lives 3.
- Assert Reset during HIT (counter=4) -> state IDLE, flash 0, hit_bcd 0x0000, lives 3 with no clock edge required. Player at px=0 with slot at ox=5 -> hit (no underflow miss).
